// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one uart_tx among NUM_REQ byte producers.
// Holds the grant across a multi-byte message until the owner flags its last byte.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int c_GAP_CLKS     = 0,
    parameter int c_TIMEOUT_CLKS = 4096
) (
    input  logic                   i_Clock,
    input  logic                   i_Reset,
    input  logic [NUM_REQ-1:0]     i_Req,
    input  logic [8*NUM_REQ-1:0]   i_Byte,
    input  logic [NUM_REQ-1:0]     i_Last,
    output logic [NUM_REQ-1:0]     o_Ack,
    output logic [NUM_REQ-1:0]     o_Grant,
    output logic                   o_TX_DV,
    output logic [7:0]             o_TX_Byte,
    input  logic                   i_TX_Active,
    input  logic                   i_TX_Done,
    output logic                   o_Busy,
    output logic                   o_Timeout
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int GW = (c_GAP_CLKS > 0) ? $clog2(c_GAP_CLKS + 1) : 1;
    localparam int TW = $clog2(c_TIMEOUT_CLKS + 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'((c_GAP_CLKS > 0) ? c_GAP_CLKS - 1 : 0);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(c_TIMEOUT_CLKS);
    localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_REQ - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_GAP} state_t;

    state_t             state_q;
    logic [IW-1:0]      ptr_q;
    logic [IW-1:0]      owner_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [NUM_REQ-1:0] ack_q;
    logic               dv_q;
    logic               last_q;
    logic               timeout_q;
    logic [7:0]         byte_q;
    logic [GW-1:0]      gap_q;
    logic [TW-1:0]      tmo_q;

    logic [TW-1:0]      tmo_d;
    logic               win_vld_d;
    logic [IW-1:0]      win_d;
    logic [IW-1:0]      cand_d;
    logic [IW-1:0]      owner_next_d;
    logic [7:0]         byte_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign byte_arr[g] = i_Byte[8*g +: 8];
    end

    // First requester at or above the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        win_vld_d = 1'b0;
        win_d     = '0;
        cand_d    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_d = IW'((int'(ptr_q) + i) % NUM_REQ);
            if (!win_vld_d && i_Req[cand_d]) begin
                win_vld_d = 1'b1;
                win_d     = cand_d;
            end
        end
    end

    assign owner_next_d = (owner_q == IDX_MAX) ? '0 : owner_q + 1'b1;
    assign tmo_d        = tmo_q + 1'b1;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            grant_q   <= '0;
            ack_q     <= '0;
            dv_q      <= 1'b0;
            last_q    <= 1'b0;
            timeout_q <= 1'b0;
            byte_q    <= 8'h00;
            gap_q     <= '0;
            tmo_q     <= '0;
        end else begin
            dv_q      <= 1'b0;
            ack_q     <= '0;
            timeout_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // A stale i_TX_Done after reset is deliberately ignored here.
                    if (!i_TX_Active && win_vld_d) begin
                        owner_q <= win_d;
                        grant_q <= NUM_REQ'(1) << win_d;
                        ack_q   <= NUM_REQ'(1) << win_d;
                        byte_q  <= byte_arr[win_d];
                        last_q  <= i_Last[win_d];
                        dv_q    <= 1'b1;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    tmo_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_TX_Done) begin
                        gap_q   <= '0;
                        state_q <= S_GAP;
                    end else if (tmo_d == TMO_LIMIT) begin
                        tmo_q     <= tmo_d;
                        timeout_q <= 1'b1;
                        grant_q   <= '0;
                        ptr_q     <= owner_next_d;
                        state_q   <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_d;
                    end
                end
                S_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        // Message lock: keep the grant while the owner has more bytes.
                        if (!last_q && i_Req[owner_q] && !i_TX_Active) begin
                            byte_q  <= byte_arr[owner_q];
                            last_q  <= i_Last[owner_q];
                            ack_q   <= grant_q;
                            dv_q    <= 1'b1;
                            state_q <= S_LOAD;
                        end else begin
                            grant_q <= '0;
                            ptr_q   <= owner_next_d;
                            state_q <= S_IDLE;
                        end
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_Ack     = ack_q;
    assign o_Grant   = grant_q;
    assign o_TX_DV   = dv_q;
    assign o_TX_Byte = byte_q;
    assign o_Busy    = (state_q != S_IDLE);
    assign o_Timeout = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: table of single-byte arbitration vectors plus
// hand-written message-lock, timeout and reset-mid-frame sequences.
module tb_uart_tx_arbiter;

    localparam int FRAME = 8;

    logic        clk = 1'b0;
    logic        i_Reset;
    logic [3:0]  i_Req;
    logic [31:0] i_Byte;
    logic [3:0]  i_Last;
    logic [3:0]  o_Ack;
    logic [3:0]  o_Grant;
    logic        o_TX_DV;
    logic [7:0]  o_TX_Byte;
    logic        o_Busy;
    logic        o_Timeout;

    logic tx_active     = 1'b0;
    logic tx_done       = 1'b0;
    int   tx_cnt        = 0;
    bit   suppress_done = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int dv_while_active = 0;
    int dv_long  = 0;
    int ack_long = 0;
    logic       prev_dv  = 1'b0;
    logic [3:0] prev_ack = 4'h0;

    uart_tx_arbiter #(
        .NUM_REQ(4),
        .c_GAP_CLKS(0),
        .c_TIMEOUT_CLKS(16)
    ) dut (
        .i_Clock(clk),
        .i_Reset(i_Reset),
        .i_Req(i_Req),
        .i_Byte(i_Byte),
        .i_Last(i_Last),
        .o_Ack(o_Ack),
        .o_Grant(o_Grant),
        .o_TX_DV(o_TX_DV),
        .o_TX_Byte(o_TX_Byte),
        .i_TX_Active(tx_active),
        .i_TX_Done(tx_done),
        .o_Busy(o_Busy),
        .o_Timeout(o_Timeout)
    );

    always #5 clk = ~clk;

    // Simplified uart_tx: FRAME active cycles, then a one-cycle done pulse.
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        tx_done <= 1'b0;
        if (o_TX_DV && tx_active) dv_while_active <= dv_while_active + 1;
        if (tx_active) begin
            if (tx_cnt == FRAME - 1) begin
                tx_active <= 1'b0;
                tx_done   <= !suppress_done;
            end else begin
                tx_cnt <= tx_cnt + 1;
            end
        end else if (o_TX_DV) begin
            tx_active <= 1'b1;
            tx_cnt    <= 0;
        end
    end

    always @(negedge clk) begin
        if (o_TX_DV && prev_dv) dv_long++;
        if ((o_Ack & prev_ack) != 4'h0) ack_long++;
        prev_dv  = o_TX_DV;
        prev_ack = o_Ack;
    end

    typedef struct {
        logic [3:0] req;
        logic [3:0] exp_grant;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_dv(output bit ok, output int at);
        ok = 1'b0;
        at = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (o_TX_DV) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
    endtask

    task automatic wait_done(output bit ok, output int at);
        ok = 1'b0;
        at = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_done) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!o_Busy) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_idle"}, ok, 1);
    endtask

    task automatic run_vec(input logic [3:0] req, input logic [3:0] eg,
                           input logic [7:0] eb, input string tag);
        bit ok;
        int at;
        i_Byte = {8'h43, 8'h42, 8'h41, 8'h40};
        i_Last = 4'hF;
        i_Req  = req;
        wait_dv(ok, at);
        check({tag, "_dv_seen"}, ok, 1);
        check({tag, "_grant"}, o_Grant, eg);
        check({tag, "_byte"}, o_TX_Byte, eb);
        check({tag, "_ack"}, o_Ack, eg);
        check({tag, "_busy"}, o_Busy, 1);
        i_Req = 4'h0;
        @(negedge clk);
        check({tag, "_dv_single"}, {o_TX_DV, o_Ack}, 5'h0);
        wait_idle(tag);
    endtask

    initial begin
        bit ok;
        int t_done;
        int t_dv;
        int t_to;

        vecs[0] = '{4'b0001, 4'b0001, 8'h40};
        vecs[1] = '{4'b0101, 4'b0100, 8'h42};
        vecs[2] = '{4'b0111, 4'b0001, 8'h40};
        vecs[3] = '{4'b1001, 4'b1000, 8'h43};
        vecs[4] = '{4'b1110, 4'b0010, 8'h41};
        vecs[5] = '{4'b0011, 4'b0001, 8'h40};
        vecs[6] = '{4'b1111, 4'b0010, 8'h41};
        vecs[7] = '{4'b1111, 4'b0100, 8'h42};
        vecs[8] = '{4'b1111, 4'b1000, 8'h43};
        vecs[9] = '{4'b1000, 4'b1000, 8'h43};

        i_Reset = 1'b1;
        i_Req   = 4'h0;
        i_Byte  = 32'h0;
        i_Last  = 4'h0;
        repeat (3) @(negedge clk);
        check("rst_grant", o_Grant, 0);
        check("rst_ack", o_Ack, 0);
        check("rst_dv", o_TX_DV, 0);
        check("rst_byte", o_TX_Byte, 0);
        check("rst_busy", o_Busy, 0);
        check("rst_timeout", o_Timeout, 0);
        i_Reset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 10; v++)
            run_vec(vecs[v].req, vecs[v].exp_grant, vecs[v].exp_byte, $sformatf("vec%0d", v));

        // Message lock: req1 sends 11,22,33 while req3 waits with 77.
        i_Byte = {8'h77, 8'h42, 8'h11, 8'h40};
        i_Last = 4'b1000;
        i_Req  = 4'b1010;
        wait_dv(ok, t_dv);
        check("lock_b1_grant", o_Grant, 4'b0010);
        check("lock_b1_byte", o_TX_Byte, 8'h11);
        i_Byte[15:8] = 8'h22;
        wait_done(ok, t_done);
        wait_dv(ok, t_dv);
        check("lock_b2_grant", o_Grant, 4'b0010);
        check("lock_b2_byte", o_TX_Byte, 8'h22);
        check("lock_b2_latency", t_dv - t_done, 2);
        i_Byte[15:8] = 8'h33;
        i_Last[1]    = 1'b1;
        wait_done(ok, t_done);
        wait_dv(ok, t_dv);
        check("lock_b3_grant", o_Grant, 4'b0010);
        check("lock_b3_byte", o_TX_Byte, 8'h33);
        check("lock_b3_latency", t_dv - t_done, 2);
        i_Req[1] = 1'b0;
        wait_done(ok, t_done);
        wait_dv(ok, t_dv);
        check("lock_next_grant", o_Grant, 4'b1000);
        check("lock_next_byte", o_TX_Byte, 8'h77);
        check("lock_next_latency", t_dv - t_done, 3);
        i_Req = 4'h0;
        wait_idle("lock");

        // Timeout: done suppressed, req2 abandoned after 16 WAIT cycles.
        suppress_done = 1'b1;
        i_Byte = {8'h43, 8'h42, 8'h41, 8'h40};
        i_Last = 4'hF;
        i_Req  = 4'b0100;
        wait_dv(ok, t_dv);
        check("to_grant", o_Grant, 4'b0100);
        i_Req = 4'h0;
        ok   = 1'b0;
        t_to = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (o_Timeout) begin
                ok   = 1'b1;
                t_to = cyc;
                break;
            end
        end
        check("to_seen", ok, 1);
        check("to_latency", t_to - t_dv, 17);
        check("to_grant_released", o_Grant, 0);
        check("to_busy", o_Busy, 0);
        @(negedge clk);
        check("to_single", o_Timeout, 0);
        suppress_done = 1'b0;
        run_vec(4'b1000, 4'b1000, 8'h43, "to_next");

        // Reset mid-frame: req1 moves the pointer to 2, then req2 frame C3 is aborted.
        run_vec(4'b0010, 4'b0010, 8'h41, "pre_rst");
        i_Byte[23:16] = 8'hC3;
        i_Req = 4'b0100;
        wait_dv(ok, t_dv);
        check("mid_grant", o_Grant, 4'b0100);
        check("mid_byte", o_TX_Byte, 8'hC3);
        i_Req = 4'h0;
        repeat (4) @(negedge clk);
        i_Reset = 1'b1;
        i_Byte  = {8'h43, 8'h5A, 8'h41, 8'h3F};
        i_Req   = 4'b0101;
        @(negedge clk);
        check("mid_rst_grant", o_Grant, 0);
        check("mid_rst_ack", o_Ack, 0);
        check("mid_rst_dv", o_TX_DV, 0);
        check("mid_rst_byte", o_TX_Byte, 0);
        check("mid_rst_busy", o_Busy, 0);
        check("mid_rst_timeout", o_Timeout, 0);
        i_Reset = 1'b0;
        wait_dv(ok, t_dv);
        check("post_rst_dv_seen", ok, 1);
        check("post_rst_grant", o_Grant, 4'b0001);
        check("post_rst_byte", o_TX_Byte, 8'h3F);
        i_Req = 4'b0100;
        wait_dv(ok, t_dv);
        check("post_rst2_grant", o_Grant, 4'b0100);
        check("post_rst2_byte", o_TX_Byte, 8'h5A);
        i_Req = 4'h0;
        wait_idle("post_rst");

        check("dv_while_active", dv_while_active, 0);
        check("dv_pulse_width", dv_long, 0);
        check("ack_pulse_width", ack_long, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
